lcd_bus_sequencer: RTL and testbench
====================================

Name: lcd_bus_sequencer

Overview:
- Owns the physical HD44780-style LCD bus (E, RS, RW, DB[7:0]).
- Before initialisation completes, it passes through the InitLCD outputs unchanged.
- After initialisation, it accepts single command/character write requests over a valid/ready handshake. For each request it generates the setup, E-pulse, hold and execution-wait timing, then signals ready for the next one.
- It sits between InitLCD, the text/command producer, and the LCD pins.

Parameters:
- T_SETUP, 2, cycles RS/DB are stable before E rises (≥1).
- T_E_HIGH, 12, cycles E is held high (≥1).
- T_HOLD, 2, cycles RS/DB are held after E falls (≥1).
- T_EXEC, 50, execution wait for normal commands and characters (≥1).
- T_EXEC_LONG, 2000, execution wait for Clear (0x01) and Return Home (0x02/0x03) with RS=0.
- CNT_W, 16, timing counter width; must hold the largest T_* value.

Ports:
- clk  in  1  system clock, same clock domain as the Taktteiler input.
- reset_n  in  1  asynchronous, active-low reset.
- init_complete_flag  in  1  from InitLCD; high once initialisation is finished.
- E_init_lcd  in  1  InitLCD enable.
- RS_init_lcd  in  1  InitLCD register select.
- RW_init_lcd  in  1  InitLCD read/write.
- data_init_lcd  in  8  InitLCD data.
- req_valid  in  1  write request present.
- req_rs  in  1  0 = command, 1 = character data.
- req_data  in  8  command or character byte.
- req_ready  out  1  sequencer can accept a request this cycle.
- busy  out  1  transfer or execution wait in progress.
- LCD_E  out  1  LCD enable pin.
- LCD_RS  out  1  LCD register select pin.
- LCD_RW  out  1  LCD read/write pin; always 0 in write states.
- LCD_DATA  out  8  LCD data bus.

Behaviour:
- Reset (async, reset_n=0):
  - state=INIT.
  - Internal registers LCD_E/LCD_RS/LCD_RW=0, LCD_DATA=8'h00.
  - req_ready=0, busy=0, counter=0, latched request cleared.
  - Note: in INIT the LCD_* pins show the InitLCD inputs (see INIT below), so the zero register values are visible on the pins only after leaving INIT.
- All other outputs are registered except in INIT, where the mux is combinational (zero latency).
- States:
  - INIT:
    - LCD_* = *_init_lcd (combinational pass-through); req_ready=0.
    - When init_complete_flag=1 → IDLE.
  - IDLE:
    - req_ready=1; LCD_E=0, LCD_RW=0; LCD_DATA/RS keep their last values.
    - On req_valid & req_ready: latch req_rs/req_data, drive LCD_RS/LCD_DATA, counter=0 → SETUP.
  - SETUP: counts T_SETUP cycles → E_HIGH.
  - E_HIGH: LCD_E=1 for exactly T_E_HIGH cycles → HOLD, where LCD_E=0.
  - HOLD: T_HOLD cycles → WAIT.
  - WAIT:
    - Waits T_EXEC_LONG if latched rs=0 and data ∈ {0x01, 0x02, 0x03}; otherwise waits T_EXEC.
    - Then → IDLE.
- Handshake:
  - A request transfers in the cycle where req_valid=1 and req_ready=1.
  - req_ready is 1 only in IDLE and falls the cycle after acceptance.
  - Inputs are ignored outside acceptance.
  - The requester must hold req_* stable while req_valid=1 and req_ready=0.
- busy=1 in SETUP, E_HIGH, HOLD and WAIT; 0 in INIT and IDLE.
- Timing:
  - Acceptance to E rising = T_SETUP+1 cycles.
  - Acceptance to req_ready high again = 1+T_SETUP+T_E_HIGH+T_HOLD+T_exec cycles.
- Counter:
  - Unsigned and reset on every state change.
  - Compared against T_x−1; never wraps.
- init_complete_flag dropping to 0:
  - In IDLE → INIT immediately.
  - In a transfer state, the transfer completes, then → INIT instead of IDLE.
- reset_n asserted mid-transfer: E drops to 0 asynchronously and the request is lost.
- Back-to-back requests: the next request is accepted on the first IDLE cycle; no extra gap.

Test Plan:
- Reset held, InitLCD driving E=1, RS=0, data=0x38 → pins show E=1, RS=0, 0x38; req_ready=0 and busy=0 throughout.
- init_complete_flag rises → next cycle req_ready=1; pins show E=0, RW=0.
- Request rs=1, data=0x41 with defaults:
  - LCD_E rises 3 cycles after acceptance and stays high 12 cycles.
  - DB=0x41 and RS=1 are stable from acceptance through end of HOLD.
  - req_ready returns 67 cycles after acceptance.
- Request rs=0, data=0x01 → execution wait of 2000 cycles; req_ready returns 2017 cycles after acceptance. Repeat with rs=1, data=0x01 → normal 67-cycle gap.
- req_valid held high with two queued requests (0x48 then 0x49) → exactly two E pulses, in order; no request dropped or duplicated.
- reset_n pulsed low during E_HIGH → LCD_E=0 within the same cycle, state INIT, busy=0.

Source files
------------

// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: owns the HD44780 LCD bus, passes InitLCD through until init completes, then sequences single writes
//   clk                 system clock
//   reset_n             asynchronous active-low reset
//   init_complete_flag  InitLCD finished; low returns the bus to InitLCD
//   *_init_lcd          InitLCD bus signals, shown on the pins while in INIT
//   req_valid/req_ready write request handshake; req_rs selects data (1) or command (0), req_data is the byte
//   busy                high during setup, E pulse, hold and execution wait
//   LCD_E/RS/RW/DATA    LCD pins
module lcd_bus_sequencer #(
   parameter int T_SETUP     = 2,
   parameter int T_E_HIGH    = 12,
   parameter int T_HOLD      = 2,
   parameter int T_EXEC      = 50,
   parameter int T_EXEC_LONG = 2000,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       init_complete_flag,
   input  logic       E_init_lcd,
   input  logic       RS_init_lcd,
   input  logic       RW_init_lcd,
   input  logic [7:0] data_init_lcd,
   input  logic       req_valid,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       busy,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA
);
   typedef enum logic [2:0] {S_INIT, S_IDLE, S_SETUP, S_E_HIGH, S_HOLD, S_WAIT} state_t;
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, wait_lim;
   logic rs_q, e_q, ready_q, busy_q, accept, long_exec;
   logic [7:0] data_q;
   assign accept = ready_q && req_valid;
   // Clear and Return Home need the long execution time
   assign long_exec = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
   assign wait_lim = long_exec ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
   always_comb begin
      state_n = state;
      case (state)
         S_INIT:   state_n = init_complete_flag ? S_IDLE : S_INIT;
         S_IDLE:   state_n = accept ? S_SETUP : (init_complete_flag ? S_IDLE : S_INIT);
         S_SETUP:  state_n = (cnt == CNT_W'(T_SETUP - 1)) ? S_E_HIGH : S_SETUP;
         S_E_HIGH: state_n = (cnt == CNT_W'(T_E_HIGH - 1)) ? S_HOLD : S_E_HIGH;
         S_HOLD:   state_n = (cnt == CNT_W'(T_HOLD - 1)) ? S_WAIT : S_HOLD;
         S_WAIT:   state_n = (cnt == wait_lim) ? (init_complete_flag ? S_IDLE : S_INIT) : S_WAIT;
         default:  state_n = S_INIT;
      endcase
      cnt_n = (state_n != state) ? '0 : cnt + CNT_W'(1);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_INIT;
         cnt     <= '0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         e_q     <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         if (accept) begin
            rs_q   <= req_rs;
            data_q <= req_data;
         end
         e_q     <= state_n == S_E_HIGH;
         ready_q <= state_n == S_IDLE;
         busy_q  <= state_n inside {S_SETUP, S_E_HIGH, S_HOLD, S_WAIT};
      end
   end
   // INIT hands the pins to InitLCD without a register stage
   assign LCD_E     = (state == S_INIT) ? E_init_lcd    : e_q;
   assign LCD_RS    = (state == S_INIT) ? RS_init_lcd   : rs_q;
   assign LCD_RW    = (state == S_INIT) ? RW_init_lcd   : 1'b0;
   assign LCD_DATA  = (state == S_INIT) ? data_init_lcd : data_q;
   assign req_ready = ready_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb_lcd_bus_sequencer: scoreboard bench for lcd_bus_sequencer, expected transfers queued by stimulus and checked by a pin monitor
module tb_lcd_bus_sequencer;
   logic clk = 0, reset_n = 0, init_complete_flag = 0;
   logic E_init_lcd = 0, RS_init_lcd = 0, RW_init_lcd = 0;
   logic [7:0] data_init_lcd = 0;
   logic req_valid = 0, req_rs = 0;
   logic [7:0] req_data = 0;
   logic req_ready, busy, LCD_E, LCD_RS, LCD_RW;
   logic [7:0] LCD_DATA;
   int checks = 0, errors = 0, cyc = 0;
   typedef struct {logic rs; logic [7:0] data; int gap;} exp_t;
   exp_t sb[$];

   lcd_bus_sequencer dut (
      .clk(clk), .reset_n(reset_n), .init_complete_flag(init_complete_flag),
      .E_init_lcd(E_init_lcd), .RS_init_lcd(RS_init_lcd), .RW_init_lcd(RW_init_lcd),
      .data_init_lcd(data_init_lcd), .req_valid(req_valid), .req_rs(req_rs),
      .req_data(req_data), .req_ready(req_ready), .busy(busy), .LCD_E(LCD_E),
      .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic rs, input logic [7:0] d, input int gap, input bit push);
      int n = 0;
      exp_t e;
      e.rs = rs; e.data = d; e.gap = gap;
      if (push) sb.push_back(e);
      req_valid = 1; req_rs = rs; req_data = d;
      @(negedge clk);
      while (!req_ready && n < 5000) begin @(negedge clk); n++; end
      chk("accept_timeout", {31'd0, req_ready}, 1);
      @(posedge clk); #1;
      req_valid = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 5000) begin @(negedge clk); n++; end
      chk("idle_timeout", {31'd0, req_ready}, 1);
   endtask

   // monitor: times each transfer on the pins and scores it when req_ready returns
   initial begin
      bit active = 0, bad = 0, e_prev = 0;
      int acc = 0, rise = -1, fall = -1, rises = 0;
      logic r0 = 0, pr = 0;
      logic [7:0] d0 = 0, pd = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) active = 0;
         else begin
            if (active) begin
               if (LCD_E && !e_prev) begin rise = cyc; rises++; pr = LCD_RS; pd = LCD_DATA; end
               if (!LCD_E && e_prev) fall = cyc;
               if (!req_ready && (LCD_RS !== r0 || LCD_DATA !== d0 || LCD_RW !== 1'b0)) bad = 1;
               if (req_ready) begin
                  active = 0;
                  if (sb.size() == 0) chk("unexpected_transfer", 1, 0);
                  else begin
                     e = sb.pop_front();
                     chk("pulse_rs", {31'd0, pr}, {31'd0, e.rs});
                     chk("pulse_data", {24'd0, pd}, {24'd0, e.data});
                     chk("pulse_count", rises, 1);
                     chk("e_rise_latency", rise - acc, 3);
                     chk("e_high_width", fall - rise, 12);
                     chk("ready_gap", cyc - acc, e.gap);
                     chk("bus_stable", {31'd0, bad}, 0);
                  end
               end
            end
            if (req_valid && req_ready) begin
               active = 1; acc = cyc; r0 = req_rs; d0 = req_data;
               rise = -1; fall = -1; rises = 0; bad = 0;
            end
         end
         e_prev = LCD_E;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int n;
      E_init_lcd = 1; RS_init_lcd = 0; data_init_lcd = 8'h38;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_ready", {31'd0, req_ready}, 0);
         chk("rst_busy", {31'd0, busy}, 0);
      end
      chk("rst_pin_e", {31'd0, LCD_E}, 1);
      chk("rst_pin_rs", {31'd0, LCD_RS}, 0);
      chk("rst_pin_data", {24'd0, LCD_DATA}, 8'h38);
      reset_n = 1;
      @(negedge clk);
      chk("init_ready", {31'd0, req_ready}, 0);
      E_init_lcd = 0; init_complete_flag = 1;
      @(negedge clk);
      chk("idle_ready", {31'd0, req_ready}, 1);
      chk("idle_e", {31'd0, LCD_E}, 0);
      chk("idle_rw", {31'd0, LCD_RW}, 0);
      chk("idle_data", {24'd0, LCD_DATA}, 0);
      chk("idle_busy", {31'd0, busy}, 0);
      #1;
      send(1, 8'h41, 67, 1);
      chk("busy_in_transfer", {31'd0, busy}, 1);
      wait_idle();
      send(0, 8'h01, 2017, 1);
      wait_idle();
      send(1, 8'h01, 67, 1);
      wait_idle();
      send(0, 8'h28, 67, 1);
      wait_idle();
      send(1, 8'h48, 67, 1);
      send(1, 8'h49, 67, 1);
      wait_idle();
      @(negedge clk);
      chk("queue_empty", sb.size(), 0);
      init_complete_flag = 0;
      @(negedge clk);
      chk("drop_ready", {31'd0, req_ready}, 0);
      chk("drop_pin_data", {24'd0, LCD_DATA}, 8'h38);
      data_init_lcd = 8'h5A; #1;
      chk("drop_passthru", {24'd0, LCD_DATA}, 8'h5A);
      init_complete_flag = 1;
      @(negedge clk);
      chk("reinit_ready", {31'd0, req_ready}, 1);
      chk("reinit_keep_data", {24'd0, LCD_DATA}, 8'h49);
      chk("reinit_keep_rs", {31'd0, LCD_RS}, 1);
      #1;
      send(1, 8'h55, 67, 0);
      n = 0;
      while (!LCD_E && n < 100) begin @(negedge clk); n++; end
      chk("e_rise_seen", {31'd0, LCD_E}, 1);
      repeat (2) @(negedge clk);
      #2 reset_n = 0;
      #1;
      chk("arst_e", {31'd0, LCD_E}, 0);
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_ready", {31'd0, req_ready}, 0);
      chk("arst_init_mux", {24'd0, LCD_DATA}, 8'h5A);
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      chk("post_arst_ready", {31'd0, req_ready}, 1);
      chk("post_arst_data", {24'd0, LCD_DATA}, 8'h00);
      chk("final_queue", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
